evt_cnt_bank: RTL and testbench

EVT_CNT_BANK -- requirements
Module: evt_cnt_bank

---
 rtl/evt_cnt_pkg.sv | 13 +
 rtl/cnt_chan.sv | 44 ++++
 rtl/evt_cnt_bank.sv | 66 ++++++
 tb/tb_evt_cnt_bank.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/evt_cnt_pkg.sv
// Shared constants and helpers for the event counter bank.
package evt_cnt_pkg;

    // Counter overflow behaviour selectors for the SAT parameter.
    localparam int unsigned CNT_WRAP = 0;
    localparam int unsigned CNT_SAT  = 1;

    // Read address width for c channels; never narrower than one bit.
    function automatic int unsigned cnt_aw(input int unsigned c);
        return (c <= 1) ? 1 : $clog2(c);
    endfunction

endpackage

// File: rtl/cnt_chan.sv
// One event counter channel: live count, snapshot register, sticky overflow flag.
module cnt_chan
    import evt_cnt_pkg::*;
#(
    parameter int unsigned N   = 16,
    parameter int unsigned SAT = CNT_WRAP
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic         latch_i,
    output logic [N-1:0] cnt_o,
    output logic [N-1:0] snap_o,
    output logic         ovf_o
);

    localparam logic [N-1:0] CNT_MAX = '1;

    // Snapshot takes the pre-edge count, so latch with clear is a lossless read-and-clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o  <= '0;
            snap_o <= '0;
            ovf_o  <= 1'b0;
        end else begin
            if (latch_i) begin
                snap_o <= cnt_o;
            end
            if (clr_i) begin
                cnt_o <= '0;
                ovf_o <= 1'b0;
            end else if (inc_i) begin
                if (cnt_o == CNT_MAX) begin
                    ovf_o <= 1'b1;
                    cnt_o <= (SAT == CNT_SAT) ? CNT_MAX : '0;
                end else begin
                    cnt_o <= cnt_o + N'(1);
                end
            end
        end
    end

endmodule

// File: rtl/evt_cnt_bank.sv
// Bank of C independent event counters with snapshot registers and a
// one-cycle-latency snapshot read port.
module evt_cnt_bank
    import evt_cnt_pkg::*;
#(
    parameter int unsigned N   = 16,
    parameter int unsigned C   = 4,
    parameter int unsigned SAT = CNT_WRAP,
    parameter int unsigned AW  = cnt_aw(C)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           clr_i,
    input  logic [C-1:0]   inc_i,
    input  logic           latch_i,
    input  logic           rd_en_i,
    input  logic [AW-1:0]  rd_addr_i,
    output logic [N-1:0]   rd_data_o,
    output logic           rd_valid_o,
    output logic [C-1:0]   ovf_o,
    output logic [C*N-1:0] cnt_o
);

    logic [N-1:0] snap_w [C];
    logic [N-1:0] rd_mux_c;

    for (genvar k = 0; k < C; k++) begin : g_chan
        cnt_chan #(
            .N   (N),
            .SAT (SAT)
        ) u_chan (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clr_i   (clr_i),
            .inc_i   (inc_i[k]),
            .latch_i (latch_i),
            .cnt_o   (cnt_o[k*N +: N]),
            .snap_o  (snap_w[k]),
            .ovf_o   (ovf_o[k])
        );
    end

    // Snapshot select; addresses beyond the last channel read as zero.
    always_comb begin
        rd_mux_c = '0;
        for (int unsigned k = 0; k < C; k++) begin
            if (rd_addr_i == AW'(k)) begin
                rd_mux_c = snap_w[k];
            end
        end
    end

    // Registered read port; data holds between requests, valid pulses per request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= rd_en_i;
            if (rd_en_i) begin
                rd_data_o <= rd_mux_c;
            end
        end
    end

endmodule

// File: tb/tb_evt_cnt_bank.sv
// Directed self-checking bench for evt_cnt_bank (N=4, C=3), wrap and saturate builds.
module tb_evt_cnt_bank;

    localparam int unsigned N  = 4;
    localparam int unsigned C  = 3;
    localparam int unsigned AW = 2;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            clr_i;
    logic [C-1:0]    inc_i;
    logic            latch_i;
    logic            rd_en_i;
    logic [AW-1:0]   rd_addr_i;

    logic [N-1:0]    rd_data_w,  rd_data_s;
    logic            rd_valid_w, rd_valid_s;
    logic [C-1:0]    ovf_w,      ovf_s;
    logic [C*N-1:0]  cnt_w,      cnt_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    evt_cnt_bank #(.N(N), .C(C), .SAT(0), .AW(AW)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (clr_i),
        .inc_i      (inc_i),
        .latch_i    (latch_i),
        .rd_en_i    (rd_en_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_w),
        .rd_valid_o (rd_valid_w),
        .ovf_o      (ovf_w),
        .cnt_o      (cnt_w)
    );

    evt_cnt_bank #(.N(N), .C(C), .SAT(1), .AW(AW)) dut_s (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (clr_i),
        .inc_i      (inc_i),
        .latch_i    (latch_i),
        .rd_en_i    (rd_en_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_s),
        .rd_valid_o (rd_valid_s),
        .ovf_o      (ovf_s),
        .cnt_o      (cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_inc(input logic [C-1:0] pat, input int cycles);
        inc_i = pat;
        for (int i = 0; i < cycles; i++) tick();
        inc_i = '0;
    endtask

    task automatic read1(input logic [AW-1:0] addr);
        rd_en_i   = 1'b1;
        rd_addr_i = addr;
        tick();
        rd_en_i   = 1'b0;
    endtask

    logic [N-1:0] exp_rd [4];
    logic [N-1:0] exp_rd_s [4];

    initial begin
        rst_i = 1'b1; clr_i = 1'b0; inc_i = '0; latch_i = 1'b0;
        rd_en_i = 1'b0; rd_addr_i = '0;
        #1;
        chk("rst_cnt",   32'(cnt_w),      32'h0);
        chk("rst_ovf",   32'(ovf_w),      32'h0);
        chk("rst_valid", 32'(rd_valid_w), 32'h0);
        chk("rst_data",  32'(rd_data_w),  32'h0);
        tick(); tick();
        rst_i = 1'b0;

        // Five counts on ch0, latch, read back.
        run_inc(3'b001, 5);
        chk("ch0_five", 32'(cnt_w), 32'h005);
        latch_i = 1'b1; tick(); latch_i = 1'b0;
        rd_en_i = 1'b1; rd_addr_i = 2'd0;
        chk("rd_not_early", 32'(rd_valid_w), 32'h0);
        tick(); rd_en_i = 1'b0;
        chk("rd0_valid", 32'(rd_valid_w), 32'h1);
        chk("rd0_data",  32'(rd_data_w),  32'h5);
        chk("ovf_none",  32'(ovf_w),      32'h0);
        tick();
        chk("rd0_pulse_end", 32'(rd_valid_w), 32'h0);
        chk("rd0_hold",      32'(rd_data_w),  32'h5);

        // Overflow on ch1, wrap vs saturate.
        run_inc(3'b010, 15);
        chk("ch1_15_w",  32'(cnt_w), 32'h0F5);
        chk("ch1_15_s",  32'(cnt_s), 32'h0F5);
        chk("ovf_pre_w", 32'(ovf_w), 32'h0);
        run_inc(3'b010, 1);
        chk("ch1_wrap0", 32'(cnt_w), 32'h005);
        chk("ch1_sat16", 32'(cnt_s), 32'h0F5);
        chk("ovf_set_w", 32'(ovf_w), 32'h2);
        chk("ovf_set_s", 32'(ovf_s), 32'h2);
        run_inc(3'b010, 1);
        chk("ch1_wrap1", 32'(cnt_w), 32'h015);
        chk("ch1_sat17", 32'(cnt_s), 32'h0F5);
        chk("ovf_hold",  32'(ovf_w), 32'h2);

        // ch2 to 7, then increment + latch + clear together.
        run_inc(3'b100, 7);
        chk("ch2_seven", 32'(cnt_w), 32'h715);
        inc_i = 3'b100; latch_i = 1'b1; clr_i = 1'b1;
        tick();
        inc_i = '0; latch_i = 1'b0; clr_i = 1'b0;
        chk("rdclr_cnt_w", 32'(cnt_w), 32'h0);
        chk("rdclr_cnt_s", 32'(cnt_s), 32'h0);
        chk("rdclr_ovf",   32'(ovf_w), 32'h0);
        read1(2'd2);
        chk("rdclr_snap2", 32'(rd_data_w), 32'h7);

        // Four back-to-back reads including an out-of-range address.
        exp_rd   = '{4'd5, 4'd1,  4'd7, 4'd0};
        exp_rd_s = '{4'd5, 4'd15, 4'd7, 4'd0};
        rd_en_i = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd_addr_i = AW'(a);
            tick();
            chk($sformatf("b2b_valid%0d", a), 32'(rd_valid_w), 32'h1);
            chk($sformatf("b2b_data%0d", a),  32'(rd_data_w),  32'(exp_rd[a]));
            chk($sformatf("b2b_sdata%0d", a), 32'(rd_data_s),  32'(exp_rd_s[a]));
        end
        rd_en_i = 1'b0;
        tick();
        chk("b2b_end", 32'(rd_valid_w), 32'h0);

        // Latch and read in the same cycle returns the old snapshot.
        run_inc(3'b001, 2);
        latch_i = 1'b1; rd_en_i = 1'b1; rd_addr_i = 2'd0;
        tick();
        latch_i = 1'b0; rd_en_i = 1'b0;
        chk("latch_rd_old", 32'(rd_data_w), 32'h5);
        read1(2'd0);
        chk("latch_rd_new", 32'(rd_data_w), 32'h2);

        // Clear beats an overflowing increment.
        run_inc(3'b001, 13);
        chk("ch0_at_max", 32'(cnt_w), 32'h00F);
        clr_i = 1'b1; inc_i = 3'b111;
        tick();
        clr_i = 1'b0; inc_i = '0;
        chk("clr_ovf_cnt", 32'(cnt_w), 32'h0);
        chk("clr_ovf_ovf", 32'(ovf_w), 32'h0);
        chk("clr_ovf_s",   32'(ovf_s), 32'h0);

        // Counters to 9/3/15 with ch2 overflowed, then async reset mid-read.
        for (int i = 0; i < 31; i++) begin
            inc_i = {1'b1, (i < 3) ? 1'b1 : 1'b0, (i < 9) ? 1'b1 : 1'b0};
            tick();
        end
        inc_i = '0;
        chk("pre_rst_cnt", 32'(cnt_w), 32'hF39);
        chk("pre_rst_ovf", 32'(ovf_w), 32'h4);
        latch_i = 1'b1; tick(); latch_i = 1'b0;
        rd_en_i = 1'b1; rd_addr_i = 2'd0;
        tick();
        chk("pre_rst_rd", 32'(rd_data_w), 32'h9);
        rd_addr_i = 2'd1;
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_cnt",   32'(cnt_w),      32'h0);
        chk("arst_ovf",   32'(ovf_w),      32'h0);
        chk("arst_valid", 32'(rd_valid_w), 32'h0);
        chk("arst_data",  32'(rd_data_w),  32'h0);
        tick();
        chk("arst_no_pulse", 32'(rd_valid_w), 32'h0);
        rst_i = 1'b0; rd_en_i = 1'b0;
        read1(2'd2);
        chk("arst_snap_valid", 32'(rd_valid_w), 32'h1);
        chk("arst_snap_zero",  32'(rd_data_w),  32'h0);

        // First count lands on the first edge after reset release.
        run_inc(3'b001, 1);
        chk("post_rst_first", 32'(cnt_w), 32'h001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
